// File: rtl/dm_4k.sv
// MEM-stage data memory: 2**ADDR_WIDTH words, combinational read, synchronous write,
// async active-high clear. Define DM_BYTE_WRITE_EN to add the 4-bit byte-lane enable port be.
module dm_4k #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rst
`ifdef DM_BYTE_WRITE_EN
  ,
  input  logic [3:0]            be
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_d;

`ifdef DM_BYTE_WRITE_EN
  // Merge enabled byte lanes of din over the current word; byte mode assumes DATA_WIDTH=32.
  always_comb begin
    wdata_d = mem_q[addr];
    for (int i = 0; i < 4; i++)
      if (be[i]) wdata_d[8*i +: 8] = din[8*i +: 8];
  end
`else
  always_comb wdata_d = din;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wdata_d;
    end
  end

  // No write-through bypass: dout shows the old word until the write edge.
  assign dout = mem_q[addr];

endmodule

// File: tb/tb_dm_4k.sv
// Scoreboard bench for dm_4k: expected read values are queued at stimulus time and
// popped when dout is sampled between clock edges.
module tb_dm_4k;
  logic [9:0]  addr;
  logic [31:0] din;
  logic        we;
  logic        clk;
  logic [31:0] dout;
  logic        rst;
`ifdef DM_BYTE_WRITE_EN
  logic [3:0]  be;
`endif

  dm_4k #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .addr (addr),
    .din  (din),
    .we   (we),
    .clk  (clk),
    .dout (dout),
    .rst  (rst)
`ifdef DM_BYTE_WRITE_EN
    ,
    .be   (be)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exq [$];
  logic [31:0] model [1024];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Drive addr between edges, queue the expectation, sample after settling.
  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    exq.push_back(exp);
    #1;
    if (exq.size() == 0) chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    else chk(tag, dout, exq.pop_front());
  endtask

  // Write on the next rising edge, then check read-after-write in the same cycle.
  task automatic wr(input string tag, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    exq.push_back(d);
    @(posedge clk);
    #1;
    we = 1'b0;
    model[a] = d;
    chk(tag, dout, exq.pop_front());
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
  endtask

  initial begin
    addr = '0; din = '0; we = 1'b0; rst = 1'b1;
`ifdef DM_BYTE_WRITE_EN
    be = 4'b1111;
`endif
    do_reset(2);
    rd("por_addr0", 10'd0, 32'h0);

    // Reset clears a previously written word and the array ends.
    wr("wr_deadbeef", 10'd5, 32'hDEADBEEF);
    do_reset(2);
    rd("rst_addr5", 10'd5, 32'h0);
    rd("rst_addr0", 10'd0, 32'h0);
    rd("rst_addr1023", 10'd1023, 32'h0);

    // Basic write/read
    wr("wr_a0", 10'd0, 32'h0);
    wr("wr_a4", 10'd4, 32'h2);
    rd("rd_a0", 10'd0, 32'h0);
    rd("rd_a4", 10'd4, 32'h2);

    // Write-disable over three edges
    @(negedge clk);
    addr = 10'd8; din = 32'h12345678; we = 1'b0;
    repeat (3) @(posedge clk);
    rd("we0_a8", 10'd8, 32'h0);

    // Combinational read follows addr without a clock
    wr("wr_a12", 10'd12, 32'hA5A5A5A5);
    @(negedge clk);
    addr = 10'd12; exq.push_back(32'hA5A5A5A5); #1 chk("comb_12a", dout, exq.pop_front());
    addr = 10'd0;  exq.push_back(32'h0);        #1 chk("comb_0",   dout, exq.pop_front());
    addr = 10'd12; exq.push_back(32'hA5A5A5A5); #1 chk("comb_12b", dout, exq.pop_front());

    // No write-through: pending din is invisible before the edge
    @(negedge clk);
    addr = 10'd12; din = 32'h0BADF00D; we = 1'b1;
    #1 chk("no_bypass", dout, 32'hA5A5A5A5);
    @(posedge clk); #1 we = 1'b0;
    model[12] = 32'h0BADF00D;
    chk("raw_after_edge", dout, 32'h0BADF00D);

    // Async reset mid-cycle with a write pending
    wr("wr_a20", 10'd20, 32'h00000055);
    @(negedge clk);
    addr = 10'd20; din = 32'h00000077; we = 1'b1;
    #2 rst = 1'b1;
    #1 chk("async_rst_drop", dout, 32'h0);
    @(posedge clk); #1;
    chk("rst_edge_nowrite", dout, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    rd("post_rst_a20", 10'd20, 32'h0);
    wr("first_wr_after_rst", 10'd20, 32'h00000099);

    // Random writes then readback against the bench's own model
    for (int i = 0; i < 16; i++)
      wr("rnd_wr", 10'($urandom_range(0, 1023)), $urandom);
    for (int i = 0; i < 16; i++) begin
      automatic logic [9:0] a = 10'($urandom_range(0, 1023));
      rd("rnd_rd", a, model[a]);
    end
    rd("rnd_rd_a20", 10'd20, model[20]);

`ifdef DM_BYTE_WRITE_EN
    be = 4'b1111;
    wr("be_full", 10'd3, 32'h11223344);
    @(negedge clk);
    addr = 10'd3; din = 32'hAABBCCDD; we = 1'b1; be = 4'b0101;
    exq.push_back(32'h11BB33DD);
    @(posedge clk); #1 we = 1'b0;
    chk("be_0101", dout, exq.pop_front());
    @(negedge clk);
    din = 32'hFFFFFFFF; we = 1'b1; be = 4'b0000;
    exq.push_back(32'h11BB33DD);
    @(posedge clk); #1 we = 1'b0;
    chk("be_0000", dout, exq.pop_front());
    be = 4'b1111;
`endif

    if (exq.size() != 0) chk("sb_leftover", 32'(exq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
